idecode_queue: RTL
==================

# idecode_queue

Buffered, handshaked instruction-decode stage between fetch and execute. It accepts fetched words with their PC into a DEPTH-entry FIFO and decodes the head entry with the existing combinational `idecoder`. Each decoded field set is presented in a registered valid/ready output slot. Unlike the bare decoder, it adds backpressure, pipeline flush, optional NOP squashing, and sticky HALT detection.

## Interface
- `DEPTH`, 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `PC_W`, 32: PC width.
- `DROP_NOP`, 0: when 1, NOPs are popped without issue.
- `CNT_W`, $clog2(DEPTH+1): occupancy width (derived).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  fetch word present.
- `in_ready`  out  1  queue can accept.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_W  its PC.
- `flush`  in  1  discard all queued and slotted instructions.
- `out_valid`  out  1  output slot holds a decoded instruction.
- `out_ready`  in  1  execute consumes slot.
- `out_instr`, `out_pc`  out  32 / PC_W  raw word and PC of slot.
- `cond` (4), `opcode` (7), `en_status` (1), `rn`, `rd`, `rs`, `rm` (4 each), `shift_op` (2), `imm5` (5), `imm12` (12), `imm24` (24)  out  decoded fields, registered.
- `halted`  out  1  HALT retired; sticky.
- `count`  out  CNT_W  FIFO occupancy, excluding the output slot.

## Operation
- Push: `in_valid && in_ready` at an edge writes {instr, pc} at the write pointer.
- `in_ready = rst_n && (count < DEPTH) && state==RUN && !flush`. There is no full-bypass.
- Head decode: `idecoder` runs combinationally on the FIFO head.
- Load: the output slot loads the head's fields plus instr and pc, and pops the head, when head is valid, (`!out_valid || out_ready`), state==RUN, and `!flush`.
- NOP squash: if `DROP_NOP`=1 and head opcode = 7'b0001001, the head is popped without loading the slot, at one per cycle. During that cycle the slot behaves as if no head were present: it empties on `out_ready`, otherwise it holds.
- Simultaneous push and pop: both occur and `count` is unchanged. Pointers wrap modulo DEPTH.
- HALT detection uses opcode 7'b0001000.
- State machine:
  - RUN: normal operation.
  - RUN → HALT_PEND when a HALT is loaded into the slot. No further loads occur in HALT_PEND.
  - HALT_PEND → HALTED when the HALT slot handshakes (`out_valid && out_ready`). At that edge: `out_valid`←0, FIFO cleared, `halted`←1.
  - HALTED is absorbing. Only `rst_n` leaves it. `in_ready`=0 and `out_valid`=0 in HALTED.
- Flush has priority over everything at its edge:
  - Pointers and `count` go to 0; `out_valid`←0.
  - A push offered in the same cycle is dropped.
  - In HALT_PEND, state returns to RUN.
  - In HALTED there is no effect.

## Timing
- Reset (async assert) values: `out_valid`=0, `halted`=0, `count`=0, state RUN, all field/instr/pc registers 0. `in_ready`=0 while `rst_n`=0.
- Latency: a word pushed at edge E0 into an empty queue with an empty slot is loaded at E1. `out_valid`=1 after E1, and `count` returns to 0 after E1.
- Throughput: 1 instruction/cycle sustained when `out_ready`=1.
- Backpressure: while `out_valid && !out_ready`, all slot outputs hold stable.
- Reset mid-operation: all state is cleared immediately, with no dependence on the clock. The first push is accepted at the first edge after deassertion.

## Structure
- Shared package (`cpu_pkg`) holds:
  - `OP_NOP`=7'b0001001 and `OP_HALT`=7'b0001000.
  - A `dec_fields_t` packed struct of all decoded fields.
- Sub-module: one instance of `idecoder` on the FIFO head.
- Storage is a flop-array FIFO inline; no separate FIFO module.

## Test plan
- Reset state: during reset, assert `out_valid`=0, `halted`=0, `count`=0, `in_ready`=0.
- Field decode through the slot: push 32'h55555555 at PC 0 → one edge later `cond`=0101, `opcode`=1011010, `en_status`=1, `rn`=`rd`=`rs`=`rm`=0101, `shift_op`=01, `imm5`=10101, `imm12`=12'h555, `imm24`=24'h555555.
- Backpressure, DEPTH=4: hold `out_ready`=0 and push 6 words → 1 word in the slot, `count`=4, `in_ready`=0. Raise `out_ready` → words retire in PC order with no loss.
- Flush: with 3 queued words, pulse `flush` together with an `in_valid` push → next cycle `count`=0 and `out_valid`=0, and the pushed word is never issued.
- NOP squash: with DROP_NOP=1, push ADD, 32'h03200000 (NOP), then B → only ADD (`opcode`=0100100) and B (`opcode`=1000110) are issued, on consecutive-but-one cycles.
- Halt: push ADD, 32'h01000000 (HALT), then ADD → ADD issues, then HALT issues. After the HALT handshake, `halted`=1, `out_valid` stays 0, and `in_ready`=0. `flush` leaves `halted`=1. Pulsing `rst_n` clears `halted`.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, decoded-field struct, queue state encoding and the
// instruction-class helper shared by the decoder and the decode queue.
package cpu_pkg;

   localparam logic [6:0] OP_HALT = 7'b0001000;
   localparam logic [6:0] OP_NOP  = 7'b0001001;

   typedef struct packed {
      logic [3:0]  cond;
      logic [6:0]  opcode;
      logic        en_status;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [3:0]  rm;
      logic [1:0]  shift_op;
      logic [4:0]  imm5;
      logic [11:0] imm12;
      logic [23:0] imm24;
   } dec_fields_t;

   typedef enum logic [1:0] {ST_RUN, ST_HALT_PEND, ST_HALTED} dq_state_e;

   // Upper opcode bits come from the instruction class in bits [27:25].
   function automatic logic [2:0] op_class(input logic [2:0] t);
      return (t[2:1] == 2'b00) ? 3'b000 :
             (t == 3'b010)     ? 3'b101 :
             (t == 3'b011)     ? 3'b010 :
             (t[2:1] == 2'b10) ? 3'b100 : 3'b110;
   endfunction

endpackage

// File: rtl/idecoder.sv
// idecoder: combinational field extraction of one 32-bit instruction word.
module idecoder
   import cpu_pkg::*;
(
   input  logic [31:0] instr,
   output dec_fields_t fields
);

   always_comb begin
      fields           = '0;
      fields.cond      = instr[31:28];
      fields.opcode    = {op_class(instr[27:25]), instr[24:21]};
      fields.en_status = instr[20];
      fields.rn        = instr[19:16];
      fields.rd        = instr[15:12];
      fields.rs        = instr[11:8];
      fields.rm        = instr[3:0];
      fields.shift_op  = instr[5:4];
      fields.imm5      = instr[10:6];
      fields.imm12     = instr[11:0];
      fields.imm24     = instr[23:0];
   end

endmodule

// File: rtl/idecode_queue.sv
// idecode_queue: FIFO-buffered decode stage with a registered valid/ready
// output slot, flush, optional NOP squashing and sticky HALT detection.
module idecode_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PC_W     = 32,
   parameter int DROP_NOP = 0,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [PC_W-1:0]  out_pc,
   output logic [3:0]       cond,
   output logic [6:0]       opcode,
   output logic             en_status,
   output logic [3:0]       rn,
   output logic [3:0]       rd,
   output logic [3:0]       rs,
   output logic [3:0]       rm,
   output logic [1:0]       shift_op,
   output logic [4:0]       imm5,
   output logic [11:0]      imm12,
   output logic [23:0]      imm24,
   output logic             halted,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   dq_state_e        state_q, state_d;
   logic [31:0]      imem_q [DEPTH];
   logic [31:0]      imem_d [DEPTH];
   logic [PC_W-1:0]  pmem_q [DEPTH];
   logic [PC_W-1:0]  pmem_d [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             out_valid_q, out_valid_d;
   logic             halted_q, halted_d;
   dec_fields_t      fld_q, fld_d;
   logic [31:0]      oinstr_q, oinstr_d;
   logic [PC_W-1:0]  opc_q, opc_d;

   dec_fields_t head_f;
   logic        head_valid, can_load, is_nop, push, pop, load, hs;

   idecoder u_dec (
      .instr  (imem_q[rptr_q]),
      .fields (head_f)
   );

   assign in_ready   = rst_n && (count_q < CNT_W'(DEPTH)) && (state_q == ST_RUN) && !flush;
   assign head_valid = (count_q != '0);
   assign can_load   = head_valid && (state_q == ST_RUN) && !flush;
   assign is_nop     = (DROP_NOP != 0) && (head_f.opcode == OP_NOP);
   assign push       = in_valid && in_ready;
   assign load       = can_load && !is_nop && (!out_valid_q || out_ready);
   assign pop        = load || (can_load && is_nop);
   assign hs         = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      imem_d      = imem_q;
      pmem_d      = pmem_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      halted_d    = halted_q;
      fld_d       = fld_q;
      oinstr_d    = oinstr_q;
      opc_d       = opc_q;
      if (flush && state_q != ST_HALTED) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
         state_d     = ST_RUN;
      end else if (state_q == ST_HALT_PEND && hs) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
         halted_d    = 1'b1;
         state_d     = ST_HALTED;
      end else begin
         if (push) begin
            imem_d[wptr_q] = in_instr;
            pmem_d[wptr_q] = in_pc;
            wptr_d         = wptr_q + 1'b1;
         end
         if (pop) rptr_d = rptr_q + 1'b1;
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (load) begin
            out_valid_d = 1'b1;
            fld_d       = head_f;
            oinstr_d    = imem_q[rptr_q];
            opc_d       = pmem_q[rptr_q];
            state_d     = (head_f.opcode == OP_HALT) ? ST_HALT_PEND : ST_RUN;
         end else if (hs) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         imem_q      <= '{default: '0};
         pmem_q      <= '{default: '0};
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
         fld_q       <= '0;
         oinstr_q    <= '0;
         opc_q       <= '0;
      end else begin
         state_q     <= state_d;
         imem_q      <= imem_d;
         pmem_q      <= pmem_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
         fld_q       <= fld_d;
         oinstr_q    <= oinstr_d;
         opc_q       <= opc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = oinstr_q;
   assign out_pc    = opc_q;
   assign cond      = fld_q.cond;
   assign opcode    = fld_q.opcode;
   assign en_status = fld_q.en_status;
   assign rn        = fld_q.rn;
   assign rd        = fld_q.rd;
   assign rs        = fld_q.rs;
   assign rm        = fld_q.rm;
   assign shift_op  = fld_q.shift_op;
   assign imm5      = fld_q.imm5;
   assign imm12     = fld_q.imm12;
   assign imm24     = fld_q.imm24;
   assign halted    = halted_q;
   assign count     = count_q;

endmodule
